// File: rtl/effect_switch_sequencer.sv
// effect_switch_sequencer: selects one of five stereo sources. Each selection change
// runs a frame-synchronous fade-out, switch, fade-in sequence so the output never steps.
module effect_switch_sequencer #(
  parameter int GAIN_BITS = 4
) (
  input  logic        AUD_BCLK,
  input  logic        rst,
  input  logic        AUD_DACLRCK,
  input  logic [3:0]  sel,
  input  logic [31:0] dryIn,
  input  logic [31:0] echoIn,
  input  logic [31:0] highIn,
  input  logic [31:0] lowIn,
  input  logic [31:0] midIn,
  output logic [31:0] audioOut,
  output logic [2:0]  activeSel,
  output logic        busy
);
  localparam logic [GAIN_BITS:0] G   = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GAIN_BITS:0] ONE = {{GAIN_BITS{1'b0}}, 1'b1};
  localparam logic [GAIN_BITS:0] ZERO = '0;
  typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} state_t;
  state_t state_q, state_d;
  logic [3:0] sync1_q, sync2_q;
  logic lrck_q, armed_q, tick, busy_q, busy_d;
  logic [GAIN_BITS:0] g_q, g_d;
  logic [2:0] act_q, act_d, tgt_q, tgt_d, req;
  logic [31:0] out_q, out_d, mid_sat, src;

  function automatic logic [15:0] sat3(input logic signed [15:0] x);
    logic signed [17:0] t;
    t = {{2{x[15]}}, x} + {x[15], x, 1'b0};
    return t > 18'sd32767 ? 16'h7fff : t < -18'sd32768 ? 16'h8000 : t[15:0];
  endfunction

  // g <= G keeps the shifted product inside 16 bits, so truncation is lossless
  function automatic logic [15:0] scale(input logic signed [15:0] x, input logic [GAIN_BITS:0] g);
    logic signed [GAIN_BITS+16:0] p;
    p = (GAIN_BITS+17)'(x) * (GAIN_BITS+17)'($signed({1'b0, g}));
    return p[GAIN_BITS+15:GAIN_BITS];
  endfunction

  // armed_q suppresses a false frame edge when LRCK is already high out of reset
  assign tick = AUD_DACLRCK & ~lrck_q & armed_q;
  assign req = sync2_q == 4'b1000 ? 3'd1 : sync2_q == 4'b0100 ? 3'd2 :
               sync2_q == 4'b0010 ? 3'd3 : sync2_q == 4'b0001 ? 3'd4 : 3'd0;
  assign mid_sat = {sat3(midIn[31:16]), sat3(midIn[15:0])};
  assign src = act_q == 3'd1 ? echoIn : act_q == 3'd2 ? highIn : act_q == 3'd3 ? lowIn :
               act_q == 3'd4 ? mid_sat : dryIn;
  assign audioOut = out_q;
  assign activeSel = act_q;
  assign busy = busy_q;

  always_comb begin
    state_d = state_q;
    g_d = g_q;
    act_d = act_q;
    tgt_d = tgt_q;
    out_d = out_q;
    if (tick) begin
      out_d = {scale(src[31:16], g_q), scale(src[15:0], g_q)};
      case (state_q)
        IDLE: if (req != act_q) begin
          tgt_d = req;
          g_d = G - ONE;
          state_d = FADE_OUT;
        end
        FADE_OUT: begin
          tgt_d = req;
          if (req == act_q) begin
            g_d = g_q + ONE;
            state_d = g_q + ONE == G ? IDLE : FADE_IN;
          end else begin
            g_d = g_q - ONE;
            state_d = g_q == ONE ? SWITCH : FADE_OUT;
          end
        end
        SWITCH: begin
          act_d = req;
          state_d = FADE_IN;
        end
        FADE_IN: if (req != act_q) begin
          tgt_d = req;
          g_d = g_q == ZERO ? g_q : g_q - ONE;
          state_d = g_q == ZERO ? SWITCH : FADE_OUT;
        end else begin
          g_d = g_q + ONE;
          state_d = g_q + ONE == G ? IDLE : FADE_IN;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge AUD_BCLK or negedge rst)
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lrck_q <= 1'b0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      g_q <= G;
      act_q <= '0;
      tgt_q <= '0;
      out_q <= '0;
      busy_q <= 1'b0;
    end else begin
      sync1_q <= sel;
      sync2_q <= sync1_q;
      lrck_q <= AUD_DACLRCK;
      armed_q <= armed_q | ~AUD_DACLRCK;
      state_q <= state_d;
      g_q <= g_d;
      act_q <= act_d;
      tgt_q <= tgt_d;
      out_q <= out_d;
      busy_q <= busy_d;
    end
endmodule
